// File: rtl/mul_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_track_ctrl
//  Description : Tracks in-flight MUL ops from EX through MEM to WB, raises a
//                stall for dependents the multiplier cannot forward, drives
//                WB write-back and the WB->ID bypass, and keeps saturating
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_track_ctrl #(
   parameter int LAT   = 2,   // edges from EX issue until the product is valid in WB
   parameter int CNT_W = 32   // performance counter width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [31:0]      mul_result,
   output logic             mul_stall_req,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic             fwd_rs1_hit,
   output logic             fwd_rs2_hit,
   output logic             busy,
   output logic [CNT_W-1:0] perf_mul_cnt,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Tracker slots: index 0 is MEM, index LAT-1 is WB.
   logic [LAT-1:0] v_q;
   logic [LAT-1:0] v_d;
   logic [4:0]     rd_q [LAT];
   logic [4:0]     rd_d [LAT];

   logic [CNT_W-1:0] mul_cnt_q;
   logic [CNT_W-1:0] mul_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   logic hazard;

   // A producer blocks ID when it writes a real register that ID actually reads.
   function automatic logic rd_hit(
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       rs1_used,
      input logic       rs2_used
   );
      return (rd != 5'd0) &&
             (((rd == rs1) && rs1_used) || ((rd == rs2) && rs2_used));
   endfunction

   // Tracker advance: shift one slot per unfrozen edge, hold everything under stall.
   always_comb begin
      v_d  = v_q;
      rd_d = rd_q;
      if (!stall) begin
         v_d[0]  = issue_valid;
         rd_d[0] = issue_rd;
         for (int k = 1; k < LAT; k++) begin
            v_d[k]  = v_q[k-1];
            rd_d[k] = rd_q[k-1];
         end
      end
   end

   // Hazard: the op in EX and every tracked op before WB cannot be forwarded yet.
   always_comb begin
      hazard = 1'b0;
      if (issue_valid && rd_hit(issue_rd, id_rs1, id_rs2, id_rs1_used, id_rs2_used)) begin
         hazard = 1'b1;
      end
      for (int k = 0; k < LAT - 1; k++) begin
         if (v_q[k] && rd_hit(rd_q[k], id_rs1, id_rs2, id_rs1_used, id_rs2_used)) begin
            hazard = 1'b1;
         end
      end
   end

   // Saturating counters; the stall counter keeps counting while the pipe is frozen.
   always_comb begin
      mul_cnt_d   = mul_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (issue_valid && !stall && (mul_cnt_q != CNT_ONES)) begin
         mul_cnt_d = mul_cnt_q + CNT_ONE;
      end
      if (hazard && (stall_cnt_q != CNT_ONES)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // State registers; reset drops any in-flight op and takes priority over stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q         <= '0;
         for (int k = 0; k < LAT; k++) begin
            rd_q[k] <= 5'd0;
         end
         mul_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         rd_q        <= rd_d;
         mul_cnt_q   <= mul_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Write-back, bypass and status outputs; x0 writes are suppressed.
   always_comb begin
      mul_stall_req  = hazard;
      wb_valid       = v_q[LAT-1] && (rd_q[LAT-1] != 5'd0);
      wb_rd          = rd_q[LAT-1];
      wb_data        = mul_result;
      fwd_rs1_hit    = wb_valid && (rd_q[LAT-1] == id_rs1) && id_rs1_used;
      fwd_rs2_hit    = wb_valid && (rd_q[LAT-1] == id_rs2) && id_rs2_used;
      busy           = |v_q;
      perf_mul_cnt   = mul_cnt_q;
      perf_stall_cnt = stall_cnt_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_track_ctrl
//  Description : Self-checking bench for mul_track_ctrl (LAT=2, CNT_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_track_ctrl;

   localparam int LAT   = 2;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             issue_valid;
   logic [4:0]       issue_rd;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [31:0]      mul_result;
   logic             mul_stall_req;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             fwd_rs1_hit;
   logic             fwd_rs2_hit;
   logic             busy;
   logic [CNT_W-1:0] perf_mul_cnt;
   logic [CNT_W-1:0] perf_stall_cnt;

   int checks   = 0;
   int failures = 0;

   logic [4:0] sb_q [$];

   mul_track_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .issue_valid    (issue_valid),
      .issue_rd       (issue_rd),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rs1_used    (id_rs1_used),
      .id_rs2_used    (id_rs2_used),
      .mul_result     (mul_result),
      .mul_stall_req  (mul_stall_req),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .fwd_rs1_hit    (fwd_rs1_hit),
      .fwd_rs2_hit    (fwd_rs2_hit),
      .busy           (busy),
      .perf_mul_cnt   (perf_mul_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        u1;
      logic        u2;
      logic [31:0] res;
      logic        e_sreq;
      logic        e_wbv;
      logic [4:0]  e_wbrd;
      logic        e_f1;
      logic        e_f2;
      logic        e_busy;
      int          e_mul;
      int          e_stl;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic iv, input logic [4:0] ird,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [31:0] res);
      stall       = st;
      issue_valid = iv;
      issue_rd    = ird;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rs1_used = u1;
      id_rs2_used = u2;
      mul_result  = res;
   endtask

   function automatic vec_t mk(input logic st, input logic iv, input logic [4:0] ird,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [31:0] res,
                               input logic sreq, input logic wbv, input logic [4:0] wbrd,
                               input logic f1, input logic f2, input logic bsy,
                               input int mc, input int sc);
      vec_t v;
      v.st = st; v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.res = res;
      v.e_sreq = sreq; v.e_wbv = wbv; v.e_wbrd = wbrd; v.e_f1 = f1; v.e_f2 = f2;
      v.e_busy = bsy; v.e_mul = mc; v.e_stl = sc;
      return v;
   endfunction

   // Scoreboard: push the destination at each accepted issue, pop at each advancing WB.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (wb_valid) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_wb", 32'(wb_rd), 32'd0);
            end else begin
               chk("sb_wb_rd", 32'(wb_rd), 32'(sb_q[0]));
               chk("sb_wb_data", wb_data, mul_result);
               if (!stall) void'(sb_q.pop_front());
            end
         end
         if (!stall && issue_valid && (issue_rd != 5'd0)) sb_q.push_back(issue_rd);
      end else begin
         sb_q.delete();
      end
   end

   initial begin
      //           st iv ird rs1 rs2 u1 u2 res   | sreq wbv wbrd f1 f2 busy mul stl
      vecs[0]  = mk(0, 1, 5, 5, 0, 1, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 5, 0, 1, 0, 0,       1, 0, 0, 0, 0, 1, 1, 1);
      vecs[2]  = mk(0, 0, 0, 5, 0, 1, 0, 42,      0, 1, 5, 1, 0, 1, 1, 2);
      vecs[3]  = mk(0, 1, 3, 0, 3, 0, 0, 0,       0, 0, 0, 0, 0, 0, 1, 2);
      vecs[4]  = mk(0, 1, 4, 0, 3, 0, 1, 0,       1, 0, 0, 0, 0, 1, 2, 2);
      vecs[5]  = mk(0, 1, 5, 0, 3, 0, 1, 100,     0, 1, 3, 0, 1, 1, 3, 3);
      vecs[6]  = mk(0, 0, 0, 4, 5, 1, 1, 101,     1, 1, 4, 1, 0, 1, 4, 3);
      vecs[7]  = mk(0, 0, 0, 5, 5, 1, 1, 102,     0, 1, 5, 1, 1, 1, 4, 4);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 4, 4);
      vecs[9]  = mk(0, 1, 0, 0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 0, 4, 4);
      vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 0,       0, 0, 0, 0, 0, 1, 5, 4);
      vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 77,      0, 0, 0, 0, 0, 1, 5, 4);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 5, 4);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 32'd123);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wbv", 32'(wb_valid), 32'd0);
      chk("rst_wbrd", 32'(wb_rd), 32'd0);
      chk("rst_sreq", 32'(mul_stall_req), 32'd0);
      chk("rst_fwd", 32'({fwd_rs1_hit, fwd_rs2_hit}), 32'd0);
      chk("rst_mulcnt", 32'(perf_mul_cnt), 32'd0);
      chk("rst_stlcnt", 32'(perf_stall_cnt), 32'd0);
      chk("rst_wbdata", wb_data, 32'd123);

      // Single MUL with dependent, back-to-back MULs, rs2 gating, x0 destination.
      for (int i = 0; i < 13; i++) begin
         @(posedge clk);
         #1 drive(vecs[i].st, vecs[i].iv, vecs[i].ird, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].res);
         @(negedge clk);
         chk($sformatf("v%0d_sreq", i), 32'(mul_stall_req), 32'(vecs[i].e_sreq));
         chk($sformatf("v%0d_wbv", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
         if (vecs[i].e_wbv) begin
            chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(vecs[i].e_wbrd));
            chk($sformatf("v%0d_wbdata", i), wb_data, vecs[i].res);
         end
         chk($sformatf("v%0d_fwd1", i), 32'(fwd_rs1_hit), 32'(vecs[i].e_f1));
         chk($sformatf("v%0d_fwd2", i), 32'(fwd_rs2_hit), 32'(vecs[i].e_f2));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d_mulcnt", i), 32'(perf_mul_cnt), 32'(vecs[i].e_mul));
         chk($sformatf("v%0d_stlcnt", i), 32'(perf_stall_cnt), 32'(vecs[i].e_stl));
      end

      // Global stall freezes MUL x9 in MEM for 4 cycles.
      @(posedge clk); #1 drive(0, 1, 9, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 drive(1, 1, 11, 0, 0, 0, 0, 0);
         @(negedge clk);
         chk("hold_wbv", 32'(wb_valid), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
         chk("hold_mulcnt", 32'(perf_mul_cnt), 32'd6);
      end
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("release_wbv", 32'(wb_valid), 32'd0);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 32'd99);
      @(negedge clk);
      chk("held_wbv", 32'(wb_valid), 32'd1);
      chk("held_wbrd", 32'(wb_rd), 32'd9);
      chk("held_mulcnt", 32'(perf_mul_cnt), 32'd6);

      // Reset (asserted together with stall) while MUL x7 sits in MEM.
      @(posedge clk); #1 drive(0, 1, 7, 0, 0, 0, 0, 0);
      @(posedge clk); #1 drive(1, 1, 7, 0, 0, 0, 0, 0); rst = 1'b1;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      @(posedge clk); #1 rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_wbrd", 32'(wb_rd), 32'd0);
      chk("mid_rst_mulcnt", 32'(perf_mul_cnt), 32'd0);
      chk("mid_rst_stlcnt", 32'(perf_stall_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("post_rst_wbv", 32'(wb_valid), 32'd0);
      end

      // Stall counter saturation: hazard held under global stall.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1 drive(1, 1, 6, 6, 0, 1, 0, 0);
         @(negedge clk);
         chk("sat_sreq", 32'(mul_stall_req), 32'd1);
         chk("sat_stlcnt", 32'(perf_stall_cnt), 32'((i > 15) ? 15 : i));
         chk("sat_mulcnt_frozen", 32'(perf_mul_cnt), 32'd0);
      end

      // Issue counter saturation with x0 destinations.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1 drive(0, 1, 0, 0, 0, 1, 1, 0);
         @(negedge clk);
         chk("sat_x0_sreq", 32'(mul_stall_req), 32'd0);
         chk("sat_mulcnt", 32'(perf_mul_cnt), 32'((i > 15) ? 15 : i));
      end
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("drain_busy", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
